traffic_req_cond: RTL and testbench

//  Input conditioner that sits directly upstream of the traffic-light FSM.

---
 rtl/traffic_req_cond.sv | 172 +++++++++++++++++
 tb/tb_traffic_req_cond.sv | 122 ++++++++++++
 2 files changed

// File: rtl/traffic_req_cond.sv
// traffic_req_cond: synchronises and debounces the raw button and sensor lines for the traffic-light FSM.
// Optional build macro TRAFFIC_REQ_STATS_EN adds o_p_cnt, a saturating count of accepted pedestrian requests.
module traffic_req_cond #(
    parameter int DB_CYCLES = 4,
    parameter int PED_HOLD  = 16,
    parameter int CNT_W     = 8
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_btn_p,
    input  logic i_btn_r,
    input  logic i_sen_a,
    input  logic i_sen_b,
    input  logic i_p_clr,
    output logic o_p,
    output logic o_r,
    output logic o_t_a,
    output logic o_t_b
`ifdef TRAFFIC_REQ_STATS_EN
    ,
    output logic [7:0] o_p_cnt
`endif
);
    localparam int IP = 0;
    localparam int IR = 1;
    localparam int IA = 2;
    localparam int IB = 3;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PED_HOLD - 1);

    typedef enum logic [1:0] {P_IDLE, P_REQ, P_BLOCK} ped_e;

    logic [3:0]       raw;
    logic [3:0]       s1_q, s2_q;
    logic [3:0]       lvl_q, lvl_d;
    logic [3:0]       edge_q, edge_d;
    logic [3:0]       flip;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    ped_e             state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             o_p_q, o_p_d;
    logic             o_r_q, o_r_d;
    logic             o_t_a_q, o_t_a_d;
    logic             o_t_b_q, o_t_b_d;
    logic             b_pend_q, b_pend_d;
    logic             b_any;

    assign raw = {i_sen_b, i_sen_a, i_btn_r, i_btn_p};

    // Two-flop synchroniser on every raw line.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Debounce: count consecutive mismatching cycles, flip the level on the DB_CYCLES-th one.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 4; i++) begin
            flip[i]  = (s2_q[i] != lvl_q[i]) && (cnt_q[i] == DB_LAST);
            cnt_d[i] = (s2_q[i] == lvl_q[i] || flip[i]) ? '0 : cnt_q[i] + 1'b1;
        end
        lvl_d  = lvl_q ^ flip;
        edge_d = flip & ~lvl_q;
    end

    // Debounced levels, counters and one-cycle rising-edge flags.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            lvl_q  <= '0;
            edge_q <= '0;
            cnt_q  <= '{default: '0};
        end else begin
            lvl_q  <= lvl_d;
            edge_q <= edge_d;
            cnt_q  <= cnt_d;
        end
    end

    // Pedestrian FSM state and hold counter.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= P_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Pedestrian next state: override wins over clear, which wins over hold expiry.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            P_IDLE: begin
                if (lvl_q[IR]) begin
                    state_d = P_BLOCK;
                end else if (edge_q[IP]) begin
                    state_d = P_REQ;
                    hold_d  = HOLD_LAST;
                end
            end
            P_REQ: begin
                if (lvl_q[IR]) begin
                    state_d = P_BLOCK;
                end else if (i_p_clr || hold_q == '0) begin
                    state_d = P_IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            P_BLOCK: state_d = lvl_q[IR] ? P_BLOCK : P_IDLE;
            default: state_d = P_IDLE;
        endcase
    end

    // Output decode; a B edge coinciding with an A pulse is parked for one cycle.
    always_comb begin
        b_any    = edge_q[IB] | b_pend_q;
        o_p_d    = (state_d == P_REQ);
        o_r_d    = lvl_q[IR];
        o_t_a_d  = edge_q[IA];
        o_t_b_d  = b_any & ~edge_q[IA];
        b_pend_d = b_any & edge_q[IA];
    end

    // Registered outputs and the pending-B flag.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_p_q    <= 1'b0;
            o_r_q    <= 1'b0;
            o_t_a_q  <= 1'b0;
            o_t_b_q  <= 1'b0;
            b_pend_q <= 1'b0;
        end else begin
            o_p_q    <= o_p_d;
            o_r_q    <= o_r_d;
            o_t_a_q  <= o_t_a_d;
            o_t_b_q  <= o_t_b_d;
            b_pend_q <= b_pend_d;
        end
    end

    assign o_p   = o_p_q;
    assign o_r   = o_r_q;
    assign o_t_a = o_t_a_q;
    assign o_t_b = o_t_b_q;

`ifdef TRAFFIC_REQ_STATS_EN
    logic [7:0] p_cnt_q, p_cnt_d;

    // Count accepted requests, saturating at 255; the serve pulse never clears it.
    always_comb begin
        p_cnt_d = (state_q == P_IDLE && state_d == P_REQ && p_cnt_q != 8'hFF) ? p_cnt_q + 8'd1 : p_cnt_q;
    end

    // Request counter register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) p_cnt_q <= '0;
        else         p_cnt_q <= p_cnt_d;
    end

    assign o_p_cnt = p_cnt_q;
`endif
endmodule

// File: tb/tb_traffic_req_cond.sv
// tb_traffic_req_cond: directed scenarios with an expected-output queue for traffic_req_cond.
module tb_traffic_req_cond;
    logic clk = 1'b0;
    logic rst_n, btn_p, btn_r, sen_a, sen_b, p_clr;
    logic o_p, o_r, o_t_a, o_t_b;
`ifdef TRAFFIC_REQ_STATS_EN
    logic [7:0] o_p_cnt;
`endif

    typedef struct {
        string      tag;
        logic [3:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    traffic_req_cond dut (
        .i_clk  (clk),
        .i_rstn (rst_n),
        .i_btn_p(btn_p),
        .i_btn_r(btn_r),
        .i_sen_a(sen_a),
        .i_sen_b(sen_b),
        .i_p_clr(p_clr),
        .o_p    (o_p),
        .o_r    (o_r),
        .o_t_a  (o_t_a),
        .o_t_b  (o_t_b)
`ifdef TRAFFIC_REQ_STATS_EN
        ,
        .o_p_cnt(o_p_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [3:0] v, input int n);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        exp_t       e;
        logic [3:0] obs;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                obs = {o_p, o_r, o_t_a, o_t_b};
                total++;
                assert (obs === e.v) else begin
                    bad++;
                    $error("FAIL %s t=%0t observed={p,r,ta,tb}=%b expected=%b", e.tag, $time, obs, e.v);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; btn_p = 1'b1; btn_r = 1'b1; sen_a = 1'b1; sen_b = 1'b1; p_clr = 1'b0;
        // reset with all raw inputs high, then release
        push("reset", 4'b0000, 3); run(3);
        rst_n = 1'b1;
        push("rel_wait", 4'b0000, 6); push("rel_r_ta", 4'b0110, 1); push("rel_tb", 4'b0101, 1);
        push("rel_hold", 4'b0100, 2); run(10);
        btn_p = 1'b0; btn_r = 1'b0; sen_a = 1'b0; sen_b = 1'b0;
        push("rel_drop", 4'b0100, 6); push("rel_low", 4'b0000, 4); run(10);
        // bouncing button, then held
        for (int s = 0; s < 10; s++) begin
            btn_p = (s % 2 == 0);
            push("bounce", 4'b0000, 2); run(2);
        end
        btn_p = 1'b1;
        push("bnc_lat", 4'b0000, 6); push("bnc_hold", 4'b1000, 16); push("bnc_end", 4'b0000, 2); run(24);
        // clear on the fifth request cycle
        btn_p = 1'b0; push("clr_idle", 4'b0000, 8); run(8);
        btn_p = 1'b1; push("clr_lat", 4'b0000, 6); push("clr_req", 4'b1000, 5); run(11);
        p_clr = 1'b1; push("clr_hit", 4'b0000, 1); run(1);
        p_clr = 1'b0; push("clr_after", 4'b0000, 3); run(3);
`ifdef TRAFFIC_REQ_STATS_EN
        chk("p_cnt", o_p_cnt, 8'd2);
`endif
        // override takes a live request and blocks presses made under it
        btn_p = 1'b0; push("ovr_idle", 4'b0000, 8); run(8);
        btn_p = 1'b1; push("ovr_lat", 4'b0000, 6); push("ovr_req", 4'b1000, 3); run(9);
        btn_r = 1'b1; push("ovr_req2", 4'b1000, 6); push("ovr_blk", 4'b0100, 1); run(7);
        btn_p = 1'b0; push("ovr_prel", 4'b0100, 8); run(8);
        btn_p = 1'b1; push("ovr_press", 4'b0100, 10); run(10);
        btn_r = 1'b0; push("ovr_rel", 4'b0100, 6); push("ovr_nop", 4'b0000, 20); run(26);
        btn_p = 1'b0; push("ovr_done", 4'b0000, 8); run(8);
        // simultaneous sensor edges
        sen_a = 1'b1; sen_b = 1'b1;
        push("sen_lat", 4'b0000, 6); push("sen_ta", 4'b0010, 1); push("sen_tb", 4'b0001, 1);
        push("sen_held", 4'b0000, 6); run(14);
        sen_a = 1'b0; sen_b = 1'b0; push("sen_fall", 4'b0000, 8); run(8);
        // async reset mid-request with B pending
        btn_p = 1'b1; push("ar_lat", 4'b0000, 6); push("ar_req", 4'b1000, 1); run(7);
        sen_a = 1'b1; sen_b = 1'b1; push("ar_slat", 4'b1000, 6); push("ar_ta", 4'b1010, 1); run(7);
        rst_n = 1'b0; btn_p = 1'b0; sen_a = 1'b0; sen_b = 1'b0;
        #1;
        chk("ar_p", {7'd0, o_p}, 8'd0);
        chk("ar_ta", {7'd0, o_t_a}, 8'd0);
        chk("ar_tb", {7'd0, o_t_b}, 8'd0);
        push("ar_in", 4'b0000, 3); run(3);
        rst_n = 1'b1; push("ar_rel", 4'b0000, 12); run(12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
